// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: tracks outstanding register writes and
// arbitrates redirect flushes, data-memory stalls and RAW/WAW interlocks.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [6:0]  id_opcode,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        issue,
    output logic        stall_if,
    output logic        stall_id,
    output logic        bubble_ex,
    output logic        flush_if_id,
    output logic        freeze,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_e      state_q, state_d;
    logic [31:0] pend_q, pend_d;
    logic [15:0] cnt_q, cnt_d;

    logic        writesRd, readsRs1, readsRs2;
    logic [31:0] effPend;
    logic        hazard;
    logic        memStall;

    assign writesRd = !(id_opcode == OP_STORE || id_opcode == OP_BRANCH);
    assign readsRs1 = !(id_opcode == OP_LUI || id_opcode == OP_AUIPC || id_opcode == OP_JAL);
    assign readsRs2 = (id_opcode == OP_OP) || (id_opcode == OP_OP32) ||
                      (id_opcode == OP_STORE) || (id_opcode == OP_BRANCH);
    assign memStall = mem_req && !mem_ready;

    // The register file writes on the falling edge, so a retiring write is already visible to ID.
    always_comb begin
        effPend = pend_q;
        if (wb_valid) begin
            effPend[wb_rd] = 1'b0;
        end
        effPend[0] = 1'b0;
        hazard = id_valid && ((readsRs1 && effPend[id_rs1]) ||
                              (readsRs2 && effPend[id_rs2]) ||
                              (writesRd && effPend[id_rd]));
    end

    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        freeze      = 1'b0;
        if (rst) begin
            case (state_q)
                RUN: begin
                    if (ex_redirect) begin
                        flush_if_id = 1'b1;
                        bubble_ex   = 1'b1;
                        state_d     = FLUSH;
                    end else if (memStall) begin
                        freeze   = 1'b1;
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        state_d  = MEM_WAIT;
                    end else if (hazard) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else begin
                        issue = id_valid;
                    end
                end
                FLUSH: begin
                    flush_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                    state_d     = memStall ? MEM_WAIT : RUN;
                end
                MEM_WAIT: begin
                    freeze   = 1'b1;
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    if (mem_ready) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Set after clear so a same-cycle retire and re-issue of one register leaves it pending.
    always_comb begin
        pend_d = pend_q;
        if (wb_valid) begin
            pend_d[wb_rd] = 1'b0;
        end
        if (issue && writesRd && (id_rd != 5'd0)) begin
            pend_d[id_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
        cnt_d = cnt_q;
        if (stall_id && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a cycle-level reference model compared on
// every falling edge, plus directed scenarios with hand-computed expectations.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        ex_redirect;
    logic        mem_req;
    logic        mem_ready;
    logic        issue, stall_if, stall_id, bubble_ex, flush_if_id, freeze;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    bit modelPend[32];
    int modelMode;
    int modelCnt;

    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BEQ  = 7'b1100011;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .issue(issue), .stall_if(stall_if), .stall_id(stall_id),
        .bubble_ex(bubble_ex), .flush_if_id(flush_if_id), .freeze(freeze),
        .state(state), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit mWritesRd(input logic [6:0] op);
        return !(op inside {SW, BEQ});
    endfunction

    function automatic bit mReadsRs1(input logic [6:0] op);
        return !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    endfunction

    function automatic bit mReadsRs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit mBusy(input int r);
        return (r != 0) && modelPend[r] && !(wb_valid && (int'(wb_rd) == r));
    endfunction

    function automatic logic [31:0] modelPendVec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = modelPend[i];
        return v;
    endfunction

    // Reference model: outputs from the current mode and inputs, then advance to the next edge.
    always @(negedge clk) begin
        bit eIssue, eStallIf, eStallId, eBubble, eFlush, eFreeze, hz, memStall;
        int nextMode;
        if (!rst) begin
            checkOutput("rst_outputs", {26'd0, issue, stall_if, stall_id, bubble_ex, flush_if_id, freeze}, 32'd0);
            checkOutput("rst_state", {30'd0, state}, 32'd0);
            checkOutput("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
            for (int i = 0; i < 32; i++) modelPend[i] = 1'b0;
            modelMode = 0;
            modelCnt  = 0;
        end else begin
            memStall = mem_req && !mem_ready;
            hz = id_valid && ((mReadsRs1(id_opcode) && mBusy(int'(id_rs1))) ||
                              (mReadsRs2(id_opcode) && mBusy(int'(id_rs2))) ||
                              (mWritesRd(id_opcode) && mBusy(int'(id_rd))));
            {eIssue, eStallIf, eStallId, eBubble, eFlush, eFreeze} = '0;
            nextMode = modelMode;
            if (modelMode == 2) begin
                eFlush = 1; eBubble = 1;
                nextMode = memStall ? 1 : 0;
            end else if (modelMode == 1) begin
                eFreeze = 1; eStallIf = 1; eStallId = 1;
                if (mem_ready) nextMode = 0;
            end else if (ex_redirect) begin
                eFlush = 1; eBubble = 1; nextMode = 2;
            end else if (memStall) begin
                eFreeze = 1; eStallIf = 1; eStallId = 1; nextMode = 1;
            end else if (hz) begin
                eStallIf = 1; eStallId = 1; eBubble = 1;
            end else begin
                eIssue = id_valid;
            end
            checkOutput("issue", {31'd0, issue}, {31'd0, eIssue});
            checkOutput("stall_if", {31'd0, stall_if}, {31'd0, eStallIf});
            checkOutput("stall_id", {31'd0, stall_id}, {31'd0, eStallId});
            checkOutput("bubble_ex", {31'd0, bubble_ex}, {31'd0, eBubble});
            checkOutput("flush_if_id", {31'd0, flush_if_id}, {31'd0, eFlush});
            checkOutput("freeze", {31'd0, freeze}, {31'd0, eFreeze});
            checkOutput("state", {30'd0, state}, modelMode);
            checkOutput("stall_cnt", {16'd0, stall_cnt}, modelCnt);
            if (wb_valid) modelPend[wb_rd] = 1'b0;
            if (eIssue && mWritesRd(id_opcode) && id_rd != 0) modelPend[id_rd] = 1'b1;
            modelMode = nextMode;
            if (eStallId && modelCnt < 65535) modelCnt++;
        end
    end

    task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd, input logic wbv,
                                 input logic [4:0] wbr, input logic redir, input logic mreq,
                                 input logic mrdy);
        @(posedge clk);
        #1;
        id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        wb_valid = wbv; wb_rd = wbr; ex_redirect = redir; mem_req = mreq; mem_ready = mrdy;
        #1;
    endtask

    task automatic idle(input logic wbv, input logic [4:0] wbr);
        applyStimulus(0, ADDI, 0, 0, 0, wbv, wbr, 0, 0, 0);
    endtask

    initial begin
        rst = 0;
        id_valid = 1; id_opcode = ADDI; id_rs1 = 0; id_rs2 = 0; id_rd = 1;
        wb_valid = 0; wb_rd = 0; ex_redirect = 1; mem_req = 1; mem_ready = 0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("lit_rst_issue", {31'd0, issue}, 32'd0);
        checkOutput("lit_rst_flush", {31'd0, flush_if_id}, 32'd0);
        checkOutput("lit_rst_freeze", {31'd0, freeze}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1;
        id_valid = 0; ex_redirect = 0; mem_req = 0;

        // RAW on x5 held until x5 retires
        applyStimulus(1, ADDI, 1, 0, 5, 0, 0, 0, 0, 0);
        checkOutput("lit_addi_issue", {31'd0, issue}, 32'd1);
        applyStimulus(1, ADD, 5, 1, 6, 0, 0, 0, 0, 0);
        checkOutput("lit_raw_stall_if", {31'd0, stall_if}, 32'd1);
        checkOutput("lit_raw_bubble", {31'd0, bubble_ex}, 32'd1);
        checkOutput("lit_raw_issue", {31'd0, issue}, 32'd0);
        applyStimulus(1, ADD, 5, 1, 6, 0, 0, 0, 0, 0);
        applyStimulus(1, ADD, 5, 1, 6, 1, 5, 0, 0, 0);
        checkOutput("lit_raw_release", {31'd0, issue}, 32'd1);
        idle(1, 6);

        // x0 is never pending
        applyStimulus(1, LUI, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, ADD, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("lit_x0_issue", {31'd0, issue}, 32'd1);
        checkOutput("lit_x0_model_pend", modelPendVec(), 32'h0);
        idle(1, 1);

        // Redirect flush: two cycles, RUN -> FLUSH -> RUN
        applyStimulus(1, ADDI, 0, 0, 10, 0, 0, 1, 0, 0);
        checkOutput("lit_redir_flush", {31'd0, flush_if_id}, 32'd1);
        checkOutput("lit_redir_issue", {31'd0, issue}, 32'd0);
        applyStimulus(1, ADDI, 0, 0, 10, 0, 0, 0, 0, 0);
        checkOutput("lit_flush_state", {30'd0, state}, 32'd2);
        idle(0, 0);
        checkOutput("lit_after_flush", {30'd0, state, flush_if_id}, 32'd0);
        checkOutput("lit_flush_model_pend", modelPendVec(), 32'h0);

        // Three waiting cycles then ready: four freeze cycles
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, ADDI, 0, 0, 0, 0, 0, 0, 1, (i == 3));
            checkOutput("lit_mem_freeze", {31'd0, freeze}, 32'd1);
            checkOutput("lit_mem_state", {30'd0, state}, (i == 0) ? 32'd0 : 32'd1);
        end
        idle(0, 0);
        checkOutput("lit_mem_release", {30'd0, state, freeze}, 32'd0);
        checkOutput("lit_mem_stall_cnt", {16'd0, stall_cnt}, 32'd6);

        // Store does not write rd; branch reads pending x3
        applyStimulus(1, ADDI, 0, 0, 3, 0, 0, 0, 0, 0);
        applyStimulus(1, SW, 2, 7, 3, 0, 0, 0, 0, 0);
        checkOutput("lit_sw_issue", {31'd0, issue}, 32'd1);
        applyStimulus(1, BEQ, 3, 4, 0, 0, 0, 0, 0, 0);
        checkOutput("lit_beq_stall", {31'd0, stall_id}, 32'd1);
        checkOutput("lit_sw_model_pend", modelPendVec(), 32'h8);
        applyStimulus(1, BEQ, 3, 4, 0, 1, 3, 0, 0, 0);
        checkOutput("lit_beq_release", {31'd0, issue}, 32'd1);

        // WAW stall, then same-cycle retire/re-issue keeps x8 pending
        applyStimulus(1, ADDI, 0, 0, 8, 0, 0, 0, 0, 0);
        applyStimulus(1, ADDI, 0, 0, 8, 0, 0, 0, 0, 0);
        checkOutput("lit_waw_stall", {31'd0, issue, stall_id}, 32'd1);
        applyStimulus(1, ADDI, 0, 0, 8, 1, 8, 0, 0, 0);
        checkOutput("lit_waw_release", {31'd0, issue}, 32'd1);
        idle(0, 0);
        checkOutput("lit_setclr_model_pend", modelPendVec(), 32'h100);
        applyStimulus(1, ADDI, 8, 0, 9, 0, 0, 0, 0, 0);
        idle(1, 8);

        // FLUSH into MEM_WAIT; redirect ignored while waiting
        applyStimulus(0, ADDI, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, ADDI, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, ADDI, 0, 0, 0, 0, 0, 1, 1, 0);
        checkOutput("lit_wait_no_flush", {30'd0, state, flush_if_id}, 32'd2);
        applyStimulus(0, ADDI, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(0, 0);

        // Saturate the counter, then reset mid-MEM_WAIT
        for (int i = 0; i < 65540; i++) applyStimulus(0, ADDI, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("lit_sat_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
        checkOutput("lit_sat_state", {30'd0, state}, 32'd1);
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        checkOutput("lit_midrst_outputs", {24'd0, state, issue, stall_if, stall_id, bubble_ex, flush_if_id, freeze}, 32'd0);
        checkOutput("lit_midrst_cnt", {16'd0, stall_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1;
        mem_req = 0;
        #1;
        checkOutput("lit_post_rst_state", {30'd0, state}, 32'd0);
        applyStimulus(1, ADD, 5, 6, 7, 0, 0, 0, 0, 0);
        checkOutput("lit_post_rst_issue", {31'd0, issue}, 32'd1);
        idle(0, 0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports as listed; one clock `clk`; reset `rst` is asynchronous and active-low.
REQ-002 clk  in  1  pipeline clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 id_valid  in  1  ID stage holds a valid instruction.
REQ-005 id_opcode  in  7  opcode of the ID instruction.
REQ-006 id_rs1, id_rs2, id_rd  in  5 each  register fields of the ID instruction.
REQ-007 wb_valid  in  1  write-back stage retiring an instruction this cycle.
REQ-008 wb_rd  in  5  write-back destination.
REQ-009 ex_redirect  in  1  EX resolved a taken branch or jump this cycle.
REQ-010 mem_req  in  1  MEM stage has a data-memory access in flight.
REQ-011 mem_ready  in  1  data memory completes the access this cycle.
REQ-012 issue  out  1  ID instruction advances to EX this cycle.
REQ-013 stall_if  out  1  hold PC and IF/ID register.
REQ-014 stall_id  out  1  hold ID outputs.
REQ-015 bubble_ex  out  1  load NOP into ID/EX.
REQ-016 flush_if_id  out  1  invalidate IF/ID contents.
REQ-017 freeze  out  1  hold EX/MEM and MEM/WB registers.
REQ-018 state  out  2  FSM state: RUN=0, MEM_WAIT=1, FLUSH=2.
REQ-019 stall_cnt  out  16  count of hazard-stall and memory-stall cycles.

Function
REQ-020 Opcode classes SHALL be as follows:
- Writes rd: every opcode except 0100011 (store) and 1100011 (branch).
- Reads rs1: every opcode except 0110111, 0010111 and 1101111.
- Reads rs2: only 0110011, 0111011, 0100011 and 1100011.
REQ-021 A 32-bit pending vector SHALL hold one bit per register with an outstanding write; bit 0 SHALL always read 0.
REQ-022 Effective pending SHALL be the pending vector with bit wb_rd masked when wb_valid=1, because the register file writes on the falling edge.
REQ-023 hazard SHALL be asserted when id_valid=1 and effective pending is set for any of:
- rs1, if the opcode reads rs1;
- rs2, if the opcode reads rs2;
- rd, if the opcode writes rd (WAW).
Register 0 is never pending.
REQ-024 Outputs SHALL be combinational from state and current inputs, with priority redirect > memory stall > hazard.
REQ-025 In RUN with ex_redirect=1: flush_if_id=1, bubble_ex=1, issue=0; next state is FLUSH.
REQ-026 In FLUSH: flush_if_id=1, bubble_ex=1, issue=0; next state is RUN, unless mem_req=1 and mem_ready=0, in which case next state is MEM_WAIT.
REQ-027 In RUN with mem_req=1, mem_ready=0 and no redirect: freeze=1, stall_if=1, stall_id=1, issue=0; next state is MEM_WAIT.
REQ-028 In MEM_WAIT:
- freeze=1, stall_if=1, stall_id=1, issue=0.
- Return to RUN in the cycle after mem_ready=1.
- ex_redirect SHALL be ignored.
REQ-029 In RUN with hazard and no redirect or memory stall: stall_if=1, stall_id=1, bubble_ex=1, issue=0; state remains RUN.
REQ-030 Otherwise, in RUN, issue SHALL equal id_valid and all other control outputs SHALL be 0.
REQ-031 On issue=1, pending[id_rd] SHALL be set when the opcode writes rd and id_rd≠0.
REQ-032 On wb_valid=1, pending[wb_rd] SHALL clear in every state; a same-cycle set and clear of one bit SHALL leave it set.
REQ-033 stall_cnt SHALL increment by 1 in each cycle with stall_id=1 and SHALL saturate at 0xFFFF.
REQ-034 Issue latency SHALL be 0 cycles: issue is valid in the same cycle as id_valid.

Reset
REQ-035 While rst=0, state SHALL be RUN, the pending vector 0, stall_cnt 0, and every control output forced to 0, regardless of inputs.
REQ-036 On rst assertion mid-operation (including in MEM_WAIT or FLUSH), state SHALL abort immediately with no further pending-vector update.
REQ-037 The first rising edge after rst rises SHALL behave as RUN with empty pending.

Verification
REQ-038 Issue of addi x5 (0010011, rd=5), then add x6,x5,x1 in ID the next cycle, with no wb → stall_if, stall_id and bubble_ex are 1 and issue=0 until wb_valid=1 with wb_rd=5; in that cycle issue=1.
REQ-039 Issue of lui x0 (0110111), then add x1,x0,x0 in ID → no stall; pending stays 0x00000000.
REQ-040 ex_redirect=1 in RUN → flush_if_id=1 for exactly 2 cycles, state sequence RUN→FLUSH→RUN, no pending bit set.
REQ-041 mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 → freeze=1 for 4 cycles, state MEM_WAIT for 3 cycles, stall_cnt=4.
REQ-042 Issue of sw x7 (0100011) while pending[7]=0, and beq x3,x4 (1100011) with pending[3]=1 → sw issues and sets no bit; beq stalls.
REQ-043 stall_cnt preset near saturation by 65540 stall cycles → reads 0xFFFF; rst low for one cycle mid-MEM_WAIT → all outputs 0, state RUN, stall_cnt 0.
